// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, divider FSM states, iteration count.
// Pure declarations, no latency or backpressure of its own.
package hilo_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Operation request / HI-LO result bundle between the pipeline (master) and the HI/LO unit (slave).
// Wires only; busy is the sole backpressure and holds off any new operation while high.
interface hilo_muldiv_if;
  import hilo_muldiv_pkg::*;

  logic        op_valid;
  op_e         op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  modport master (
    output op_valid, op, rs_data, rt_data, flush,
    input  hi, lo, busy
  );

  modport slave (
    input  op_valid, op, rs_data, rt_data, flush,
    output hi, lo, busy
  );

endinterface

// File: rtl/hilo_muldiv_div_core.sv
// Restoring 32-bit divider on magnitudes: 32 RUN cycles, one FIX cycle for sign correction (33 busy cycles).
// Accepts start only in IDLE; flush aborts RUN/FIX at the next edge and suppresses done.
module div_core
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_flush,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rem;
  logic [31:0]      r_quo;
  logic [31:0]      r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  logic             w_dz;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [31:0]      w_mag_a;
  logic [31:0]      w_mag_b;
  logic [32:0]      w_shift;
  logic [32:0]      w_trial;
  logic             w_take;
  logic             w_launch;

  // Divide-by-zero keeps the raw dividend so the remainder comes out as rs_data unmodified.
  assign w_dz     = (i_divisor == 32'd0);
  assign w_a_neg  = i_signed & i_dividend[31] & ~w_dz;
  assign w_b_neg  = i_signed & i_divisor[31];
  assign w_mag_a  = w_a_neg ? neg32(i_dividend) : i_dividend;
  assign w_mag_b  = w_b_neg ? neg32(i_divisor) : i_divisor;
  assign w_launch = (r_state == ST_IDLE) & i_start & ~i_flush;

  assign w_shift  = {r_rem, r_quo[31]};
  assign w_trial  = w_shift - {1'b0, r_dvs};
  assign w_take   = ~w_trial[32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (i_flush)                w_state_nxt = ST_IDLE;
        else if (r_cnt == CNT_LAST) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        o_busy      = 1'b1;
        o_done      = ~i_flush;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_launch) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_mag_a;
      r_dvs   <= w_mag_b;
      r_neg_q <= w_a_neg ^ (w_b_neg & ~w_dz);
      r_neg_r <= w_a_neg;
      r_dz    <= w_dz;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_rem <= w_take ? w_trial[31:0] : {r_rem[30:0], r_quo[31]};
      r_quo <= {r_quo[30:0], w_take};
    end
  end

  assign o_quotient  = r_dz ? 32'hFFFF_FFFF : (r_neg_q ? neg32(r_quo) : r_quo);
  assign o_remainder = r_neg_r ? neg32(r_rem) : r_rem;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO unit: single-cycle MULT/MULTU/MTHI/MTLO, 33-cycle DIV/DIVU through div_core.
// Ops are taken only when idle and not flushed; busy stalls later HI/LO users during division.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  hilo_muldiv_if.slave bus
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_busy;
  logic        w_done;
  logic        w_accept;
  logic        w_start_div;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_accept    = bus.op_valid & ~w_busy & ~bus.flush;
  assign w_start_div = w_accept & ((bus.op == OP_DIV) | (bus.op == OP_DIVU));

  // Operands are pre-extended so the low 64 bits of the product are exact.
  assign w_prod_s = {{32{bus.rs_data[31]}}, bus.rs_data} * {{32{bus.rt_data[31]}}, bus.rt_data};
  assign w_prod_u = {32'd0, bus.rs_data} * {32'd0, bus.rt_data};

  div_core u_div_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_start_div),
    .i_flush     (bus.flush),
    .i_signed    (bus.op == OP_DIV),
    .i_dividend  (bus.rs_data),
    .i_divisor   (bus.rt_data),
    .o_busy      (w_busy),
    .o_done      (w_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      r_hi <= w_rem;
      r_lo <= w_quo;
    end else if (w_accept) begin
      case (bus.op)
        OP_MULT:  {r_hi, r_lo} <= w_prod_s;
        OP_MULTU: {r_hi, r_lo} <= w_prod_u;
        OP_MTHI:  r_hi <= bus.rs_data;
        OP_MTLO:  r_lo <= bus.rs_data;
        default:  ;
      endcase
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.busy = w_busy;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: expected HI/LO pairs are queued as each op is driven and popped when the result is due.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_if dif();

  hilo_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_total = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi  = 32'd0;
  logic [31:0] cur_lo  = 32'd0;
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] e_hi, input logic [31:0] e_lo);
    exp_q.push_back({e_hi, e_lo});
  endtask

  task automatic check_sb(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_hi"}, dif.hi, e[63:32]);
      chk({tag, "_lo"}, dif.lo, e[31:0]);
      cur_hi = e[63:32];
      cur_lo = e[31:0];
    end
  endtask

  // Entered and left on a falling edge; the accepting rising edge lies in between.
  task automatic issue(input op_e op, input logic [31:0] rs, input logic [31:0] rt);
    dif.op_valid = 1'b1;
    dif.op       = op;
    dif.rs_data  = rs;
    dif.rt_data  = rt;
    @(negedge clk);
    dif.op_valid = 1'b0;
    dif.op       = OP_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (dif.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_div(input string tag, input op_e op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] e_hi, input logic [31:0] e_lo);
    int n;
    push(e_hi, e_lo);
    issue(op, rs, rt);
    wait_idle(n);
    chk({tag, "_busy_cycles"}, 32'(n), 32'd33);
    check_sb(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench stopped by time limit");
  end

  initial begin
    dif.op_valid = 1'b0;
    dif.op       = OP_NONE;
    dif.rs_data  = 32'd0;
    dif.rt_data  = 32'd0;
    dif.flush    = 1'b0;

    #3;
    chk("reset_hi", dif.hi, 32'd0);
    chk("reset_lo", dif.lo, 32'd0);
    chk("reset_busy", 32'(dif.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    push(32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check_sb("mult");

    push(32'h0000_0002, 32'hFFFF_FFFA);
    issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    check_sb("multu");

    push(32'h1234_5678, cur_lo);
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    check_sb("mthi");

    push(cur_hi, 32'h0BAD_F00D);
    issue(OP_MTLO, 32'h0BAD_F00D, 32'd0);
    check_sb("mtlo");

    run_div("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("divu_by0",    OP_DIVU, 32'd100,       32'd0,          32'h0000_0064, 32'hFFFF_FFFF);
    run_div("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000);
    run_div("divu_big",    OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010,  32'h0000_000F, 32'h0FFF_FFFF);
    run_div("div_7_m2",    OP_DIV,  32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD);
    run_div("div_m7_m2",   OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'h0000_0003);
    run_div("div_neg_by0", OP_DIV,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Flush on busy cycle 10 discards the division.
    push(32'h1111_1111, cur_lo);
    issue(OP_MTHI, 32'h1111_1111, 32'd0);
    check_sb("mthi_pre");
    issue(OP_DIV, 32'd50, 32'd7);
    repeat (9) @(negedge clk);
    chk("flush_run_busy_before", 32'(dif.busy), 32'd1);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    chk("flush_run_busy_after", 32'(dif.busy), 32'd0);
    push(cur_hi, cur_lo);
    check_sb("flush_run");

    // Flush in the FIX cycle beats the result write.
    issue(OP_DIV, 32'd50, 32'd7);
    repeat (32) @(negedge clk);
    chk("flush_fix_busy_before", 32'(dif.busy), 32'd1);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    chk("flush_fix_busy_after", 32'(dif.busy), 32'd0);
    push(cur_hi, cur_lo);
    check_sb("flush_fix");

    // Flush alongside op_valid cancels the op.
    dif.flush = 1'b1;
    push(cur_hi, cur_lo);
    issue(OP_MULTU, 32'd3, 32'd4);
    check_sb("flush_same_mult");
    issue(OP_DIV, 32'd50, 32'd7);
    dif.flush = 1'b0;
    chk("flush_same_div_busy", 32'(dif.busy), 32'd0);

    // MTLO offered on busy cycle 5 is ignored.
    push(32'd1, 32'd7);
    issue(OP_DIV, 32'd50, 32'd7);
    repeat (4) @(negedge clk);
    issue(OP_MTLO, 32'hAAAA_5555, 32'd0);
    wait_idle(cyc);
    chk("mtlo_busy_remaining", 32'(cyc), 32'd28);
    check_sb("div_ignore_mtlo");

    // Reset on busy cycle 20.
    issue(OP_DIVU, 32'd100, 32'd3);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", dif.hi, 32'd0);
    chk("midrst_lo", dif.lo, 32'd0);
    chk("midrst_busy", 32'(dif.busy), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    push(32'd0, 32'd12);
    issue(OP_MULTU, 32'd3, 32'd4);
    check_sb("post_rst_multu");

    run_div("post_rst_div", OP_DIV, 32'd50, 32'd7, 32'd1, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
